// File: rtl/ft600_pkg.sv
// Shared types for the FT600 TX buffer.
//   ft600_word_t : one buffered entry, byte enables above the 16-bit data word
//   BE_*         : byte-enable encodings ([0] = low byte)
//   fifo_state_e : occupancy state of the TX FIFO
package ft600_pkg;

  typedef struct packed {
    logic [1:0]  be;
    logic [15:0] data;
  } ft600_word_t;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LOW  = 2'b01;
  localparam logic [1:0] BE_HIGH = 2'b10;
  localparam logic [1:0] BE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/ft600_tx_fifo_if.sv
// Bus bundle between the FPGA producer / FT600 send stage (master) and the
// TX FIFO (slave).
//   push side : wr_en, wr_data, wr_be -> ; <- full, almost_full, level, overflow
//   pop side  : ready_to_recieve ->     ; <- data_to_ft600, be_to_ft600, empty
//   stats     : push_cnt, pop_cnt, drop_cnt (only with FT600_TX_FIFO_STATS_EN)
interface ft600_tx_fifo_if #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              wr_en;
  logic [15:0]       wr_data;
  logic [1:0]        wr_be;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              ready_to_recieve;
  logic [15:0]       data_to_ft600;
  logic [1:0]        be_to_ft600;
  logic              empty;
`ifdef FT600_TX_FIFO_STATS_EN
  logic [31:0]       push_cnt;
  logic [31:0]       pop_cnt;
  logic [15:0]       drop_cnt;
`endif

  modport master (
    output wr_en, wr_data, wr_be, ready_to_recieve,
    input  full, almost_full, level, overflow, data_to_ft600, be_to_ft600, empty
`ifdef FT600_TX_FIFO_STATS_EN
    , input push_cnt, pop_cnt, drop_cnt
`endif
  );

  modport slave (
    input  wr_en, wr_data, wr_be, ready_to_recieve,
    output full, almost_full, level, overflow, data_to_ft600, be_to_ft600, empty
`ifdef FT600_TX_FIFO_STATS_EN
    , output push_cnt, pop_cnt, drop_cnt
`endif
  );
endinterface

// File: rtl/ft600_sdp_ram.sv
// Simple dual-port RAM, DEPTH x 18, synchronous write and synchronous read
// (read returns the old contents on a same-address write).
//   clk   : write/read clock
//   we    : write enable; waddr/wdata write port
//   raddr : read address, rdata valid the cycle after
module ft600_sdp_ram
  import ft600_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  ft600_word_t       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output ft600_word_t       rdata
);
  ft600_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ft600_tx_fifo.sv
// FT600 upstream TX FIFO, first-word-fall-through, ftdi_clk domain.
//   ftdi_clk, rst_n (async, active-low)
//   bus : ft600_tx_fifo_if.slave (push port, pop port, flags, level)
// Optional build macro FT600_TX_FIFO_STATS_EN adds push/pop/drop counters.
//
// The head word lives in an output register; the RAM holds the words behind
// it, so the RAM never holds more than DEPTH-1 entries. The RAM read address
// tracks the next read pointer so the word behind the head is already read
// out when a pop arrives. A write landing on that address in the same cycle
// is caught by a one-entry bypass.
//
// state     | meaning
// ST_EMPTY  | level == 0, be_to_ft600 = 00
// ST_ACTIVE | 0 < level < DEPTH
// ST_FULL   | level == DEPTH, pushes only accepted with a same-cycle pop
module ft600_tx_fifo
  import ft600_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int AFULL_THRESH = DEPTH - 8,
  parameter int ADDR_W       = $clog2(DEPTH)
) (
  input logic            ftdi_clk,
  input logic            rst_n,
  ft600_tx_fifo_if.slave bus
);
  typedef logic [ADDR_W:0] lvl_t;

  fifo_state_e       state_q, state_d;
  lvl_t              level_q, level_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  ft600_word_t       head_q, head_d;
  ft600_word_t       byp_q, byp_d;
  logic              byp_sel_q, byp_sel_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;

  ft600_word_t       wr_word, ram_rdata, ram_head;
  logic              head_valid, pop_ok, push_ok, ram_has, ram_we;

  ft600_sdp_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (ftdi_clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wr_word),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_word    = '{be: bus.wr_be, data: bus.wr_data};
    head_valid = (state_q != ST_EMPTY);
    pop_ok     = bus.ready_to_recieve && head_valid;
    // a pop frees a slot in the same cycle, so a full FIFO still takes the push
    push_ok    = bus.wr_en && ((state_q != ST_FULL) || pop_ok);
    ram_has    = (level_q > lvl_t'(1));
    ram_head   = byp_sel_q ? byp_q : ram_rdata;
    // the word goes straight to the head register when nothing is ahead of it
    ram_we     = push_ok && head_valid && !(pop_ok && !ram_has);

    level_d = level_q;
    if (push_ok && !pop_ok) level_d = level_q + lvl_t'(1);
    else if (!push_ok && pop_ok) level_d = level_q - lvl_t'(1);

    if (level_d == '0) state_d = ST_EMPTY;
    else if (level_d == lvl_t'(DEPTH)) state_d = ST_FULL;
    else state_d = ST_ACTIVE;

    afull_d = (level_d >= lvl_t'(AFULL_THRESH));
    ovf_d   = ovf_q || (bus.wr_en && !push_ok);

    wr_ptr_d = wr_ptr_q;
    if (ram_we) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop_ok && ram_has) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    byp_sel_d = ram_we && (wr_ptr_q == rd_ptr_d);
    byp_d     = ram_we ? wr_word : byp_q;

    head_d = head_q;
    if (!head_valid) begin
      if (push_ok) head_d = wr_word;
    end else if (pop_ok) begin
      if (ram_has) head_d = ram_head;
      else if (push_ok) head_d = wr_word;
      else head_d.be = BE_NONE;  // drained: data holds its last value
    end
  end

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      head_q    <= '{be: BE_NONE, data: 16'h0000};
      byp_q     <= '{be: BE_NONE, data: 16'h0000};
      byp_sel_q <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      head_q    <= head_d;
      byp_q     <= byp_d;
      byp_sel_q <= byp_sel_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.full          = (state_q == ST_FULL);
  assign bus.empty         = (state_q == ST_EMPTY);
  assign bus.almost_full   = afull_q;
  assign bus.level         = level_q;
  assign bus.overflow      = ovf_q;
  assign bus.data_to_ft600 = head_q.data;
  assign bus.be_to_ft600   = head_q.be;

`ifdef FT600_TX_FIFO_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] pop_cnt_q, pop_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    push_cnt_d = push_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (push_ok) push_cnt_d = push_cnt_q + 32'd1;
    if (pop_ok) pop_cnt_d = pop_cnt_q + 32'd1;
    if (bus.wr_en && !push_ok && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.push_cnt = push_cnt_q;
  assign bus.pop_cnt  = pop_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_ft600_tx_fifo.sv
module tb_ft600_tx_fifo;
  import ft600_pkg::*;

  localparam int DEPTH = 512;

  logic ftdi_clk;
  logic rst_n;

  ft600_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  ft600_tx_fifo #(.DEPTH(DEPTH)) dut (
    .ftdi_clk (ftdi_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial ftdi_clk = 1'b0;
  always #5 ftdi_clk = ~ftdi_clk;

  int n_chk;
  int n_fail;

  logic [17:0] mq [$];
  logic [15:0] m_data;
  logic        m_ovf;
  logic [31:0] m_pushes;
  logic [31:0] m_pops;
  logic [15:0] m_drops;

  typedef struct {
    logic        wr;
    logic [15:0] d;
    logic [1:0]  be;
    logic        rtr;
    logic        e_empty;
    logic [15:0] e_data;
    logic [1:0]  e_be;
    int          e_level;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_data   = 16'h0000;
    m_ovf    = 1'b0;
    m_pushes = '0;
    m_pops   = '0;
    m_drops  = '0;
  endtask

  // Apply one cycle of stimulus, step the reference queue, sample 1ns after the edge.
  task automatic drive(input logic wr, input logic [15:0] d, input logic [1:0] be, input logic rtr);
    logic pop_ok, push_ok;
    bus.wr_en            = wr;
    bus.wr_data          = d;
    bus.wr_be            = be;
    bus.ready_to_recieve = rtr;
    @(posedge ftdi_clk);
    pop_ok  = rtr && (mq.size() != 0);
    push_ok = wr && ((mq.size() < DEPTH) || pop_ok);
    if (wr && !push_ok) begin
      m_ovf = 1'b1;
      if (m_drops != 16'hFFFF) m_drops++;
    end
    if (pop_ok) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (push_ok) begin
      mq.push_back({be, d});
      m_pushes++;
    end
    if (mq.size() != 0) m_data = mq[0][15:0];
    #1;
    bus.wr_en            = 1'b0;
    bus.ready_to_recieve = 1'b0;
  endtask

  task automatic check_model();
    logic [1:0] exp_be;
    exp_be = (mq.size() != 0) ? mq[0][17:16] : BE_NONE;
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("level", 32'(bus.level), 32'(mq.size()));
    chk("be", 32'(bus.be_to_ft600), 32'(exp_be));
    chk("data", 32'(bus.data_to_ft600), 32'(m_data));
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= DEPTH - 8));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef FT600_TX_FIFO_STATS_EN
    chk("push_cnt", bus.push_cnt, m_pushes);
    chk("pop_cnt", bus.pop_cnt, m_pops);
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
`endif
  endtask

  task automatic step(input logic wr, input logic [15:0] d, input logic [1:0] be, input logic rtr);
    drive(wr, d, be, rtr);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge ftdi_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " empty"}, 32'(bus.empty), 32'd1);
    chk({tag, " full"}, 32'(bus.full), 32'd0);
    chk({tag, " almost_full"}, 32'(bus.almost_full), 32'd0);
    chk({tag, " overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, " level"}, 32'(bus.level), 32'd0);
    chk({tag, " data"}, 32'(bus.data_to_ft600), 32'h0000);
    chk({tag, " be"}, 32'(bus.be_to_ft600), 32'(BE_NONE));
`ifdef FT600_TX_FIFO_STATS_EN
    chk({tag, " push_cnt"}, bus.push_cnt, 32'd0);
    chk({tag, " pop_cnt"}, bus.pop_cnt, 32'd0);
    chk({tag, " drop_cnt"}, 32'(bus.drop_cnt), 32'd0);
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    bus.wr_en            = 1'b0;
    bus.wr_data          = 16'h0000;
    bus.wr_be            = BE_NONE;
    bus.ready_to_recieve = 1'b0;
    rst_n                = 1'b0;
    model_clear();

    //         wr    data      be       rtr  | empty data      be       level
    vt[0]  = '{1'b0, 16'h0000, BE_NONE, 1'b1, 1'b1, 16'h0000, BE_NONE, 0};
    vt[1]  = '{1'b1, 16'hA5A5, BE_BOTH, 1'b1, 1'b0, 16'hA5A5, BE_BOTH, 1};
    vt[2]  = '{1'b0, 16'h0000, BE_NONE, 1'b0, 1'b0, 16'hA5A5, BE_BOTH, 1};
    vt[3]  = '{1'b0, 16'h0000, BE_NONE, 1'b1, 1'b1, 16'hA5A5, BE_NONE, 0};
    vt[4]  = '{1'b1, 16'h0001, BE_LOW,  1'b0, 1'b0, 16'h0001, BE_LOW,  1};
    vt[5]  = '{1'b1, 16'h0002, BE_HIGH, 1'b0, 1'b0, 16'h0001, BE_LOW,  2};
    vt[6]  = '{1'b1, 16'h0003, BE_BOTH, 1'b0, 1'b0, 16'h0001, BE_LOW,  3};
    vt[7]  = '{1'b1, 16'h0004, BE_LOW,  1'b0, 1'b0, 16'h0001, BE_LOW,  4};
    vt[8]  = '{1'b0, 16'h0000, BE_NONE, 1'b1, 1'b0, 16'h0002, BE_HIGH, 3};
    vt[9]  = '{1'b0, 16'h0000, BE_NONE, 1'b1, 1'b0, 16'h0003, BE_BOTH, 2};
    vt[10] = '{1'b0, 16'h0000, BE_NONE, 1'b1, 1'b0, 16'h0004, BE_LOW,  1};
    vt[11] = '{1'b0, 16'h0000, BE_NONE, 1'b1, 1'b1, 16'h0004, BE_NONE, 0};
    vt[12] = '{1'b1, 16'h0010, BE_HIGH, 1'b0, 1'b0, 16'h0010, BE_HIGH, 1};
    vt[13] = '{1'b1, 16'h0011, BE_LOW,  1'b1, 1'b0, 16'h0011, BE_LOW,  1};
    vt[14] = '{1'b1, 16'h0012, BE_BOTH, 1'b1, 1'b0, 16'h0012, BE_BOTH, 1};
    vt[15] = '{1'b0, 16'h0000, BE_NONE, 1'b1, 1'b1, 16'h0012, BE_NONE, 0};
    vt[16] = '{1'b0, 16'h0000, BE_NONE, 1'b1, 1'b1, 16'h0012, BE_NONE, 0};

    repeat (2) @(posedge ftdi_clk);
    #1;
    chk_reset_values("in_reset");
    rst_n = 1'b1;
    @(posedge ftdi_clk);
    #1;
    chk_reset_values("after_reset");

    // basic push/pop vectors
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].wr, vt[i].d, vt[i].be, vt[i].rtr);
      chk($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(vt[i].e_empty));
      chk($sformatf("vec%0d data", i), 32'(bus.data_to_ft600), 32'(vt[i].e_data));
      chk($sformatf("vec%0d be", i), 32'(bus.be_to_ft600), 32'(vt[i].e_be));
      chk($sformatf("vec%0d level", i), 32'(bus.level), 32'(vt[i].e_level));
    end

    // fill to full, push+pop at full, then overflow with DEAD, drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i), BE_BOTH, 1'b0);
    chk("fill full", 32'(bus.full), 32'd1);
    chk("fill overflow", 32'(bus.overflow), 32'd0);
    step(1'b1, 16'h0BEE, BE_HIGH, 1'b1);
    chk("full push+pop level", 32'(bus.level), 32'(DEPTH));
    chk("full push+pop overflow", 32'(bus.overflow), 32'd0);
    step(1'b1, 16'hDEAD, BE_BOTH, 1'b0);
    chk("dead overflow", 32'(bus.overflow), 32'd1);
    chk("dead level", 32'(bus.level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("no dead", 32'(bus.data_to_ft600 == 16'hDEAD), 32'd0);
      step(1'b0, 16'h0000, BE_NONE, 1'b1);
    end
    chk("drain overflow sticky", 32'(bus.overflow), 32'd1);

    // steady push+pop at level 5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0100 + 16'(i), BE_LOW, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h0200 + 16'(i), BE_HIGH, 1'b1);
      chk("steady level", 32'(bus.level), 32'd5);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, BE_NONE, 1'b1);

    // pointer wrap with interleaved pops
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++)
      step(1'b1, 16'h4000 + 16'(i), 2'(i), (i % 4) != 0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 16'h0000, BE_NONE, 1'b1);
    chk("wrap drained", 32'(bus.empty), 32'd1);

    // async reset mid-stream at level 20
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 16'h7000 + 16'(i), BE_BOTH, 1'b0);
    chk("pre-reset level", 32'(bus.level), 32'd20);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_reset_values("midstream");
    @(posedge ftdi_clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0C00 + 16'(i), BE_LOW, 1'b0);
    step(1'b0, 16'h0000, BE_NONE, 1'b1);
    chk("post-reset level", 32'(bus.level), 32'd2);
    chk("post-reset head", 32'(bus.data_to_ft600), 32'h0C01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
